wb_port_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources.
- Source A is the in-order pipeline writeback: highest priority, no backpressure.
- Source B is the multi-cycle mul/div unit, using a valid/ready handshake.
- Keeps a pending-write scoreboard so decode can stall on registers still owed by B, and guarantees B cannot starve.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback-source tag.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Which source owns the write currently sitting in the rf_* output register.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_A,
    WB_B
  } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register still owed by the mul/div unit.
// A new issue (set) beats a same-edge commit (clear); r0 is never pending.
module wb_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                clrn,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_wn,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_wn,
  input  logic [REG_AW-1:0]   qa,
  input  logic [REG_AW-1:0]   qb,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] pend
);

  logic [NUM_REGS-1:0] sb_reg;
  logic [NUM_REGS-1:0] sb_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_r0
        assign sb_next[gi] = 1'b0;
      end else begin : g_rn
        // Set has priority so a re-issue on the commit edge stays pending.
        always_comb begin
          sb_next[gi] = sb_reg[gi];
          if (clr_en && (clr_wn == REG_AW'(gi))) sb_next[gi] = 1'b0;
          if (set_en && (set_wn == REG_AW'(gi))) sb_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // Pending bits register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) sb_reg <= '0;
    else       sb_reg <= sb_next;
  end

  assign busy_a = sb_reg[qa];
  assign busy_b = sb_reg[qb];
  assign pend   = sb_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline (A, priority)
// and the mul/div unit (B, valid/ready), with starvation guard and scoreboard.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              a_we,
  input  logic [REG_AW-1:0] a_wn,
  input  logic [DATA_W-1:0] a_d,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_wn,
  input  logic [DATA_W-1:0] b_d,
  output logic              b_ready,
  output logic              stall_a,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_wn,
  input  logic [REG_AW-1:0] rna,
  input  logic [REG_AW-1:0] rnb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wn,
  output logic [DATA_W-1:0] rf_d,
  output logic              err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              rf_we_reg;
  logic [REG_AW-1:0] rf_wn_reg;
  logic [DATA_W-1:0] rf_d_reg;
  wb_src_t           src_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic              err_next;

  logic                a_eff;
  logic                sb_set_eff;
  logic                clr_en;
  logic [NUM_REGS-1:0] pend;

  // A write to r0 is no write at all.
  assign a_eff      = a_we && (a_wn != '0);
  assign sb_set_eff = sb_set && (sb_wn != '0);
  // The register file stores B's data on this same edge, so busy drops with it.
  assign clr_en     = rf_we_reg && (src_reg == WB_B);

  assign stall_a = b_valid && (cnt_reg == LIMIT);
  assign b_ready = b_valid && (!a_eff || stall_a);

  wb_scoreboard u_sb (
    .clk    (clk),
    .clrn   (clrn),
    .set_en (sb_set_eff),
    .set_wn (sb_wn),
    .clr_en (clr_en),
    .clr_wn (rf_wn_reg),
    .qa     (rna),
    .qb     (rnb),
    .busy_a (busy_a),
    .busy_b (busy_b),
    .pend   (pend)
  );

  // Protocol checks: double issue, WAW against an owed register, orphan B result.
  always_comb begin
    err_next = err_reg;
    if (sb_set_eff && pend[sb_wn] && !(clr_en && (rf_wn_reg == sb_wn))) err_next = 1'b1;
    if (a_eff && pend[a_wn])                                           err_next = 1'b1;
    if (b_valid && !pend[b_wn])                                        err_next = 1'b1;
  end

  // Write-port output register; a granted B beats A, idle holds address/data.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rf_we_reg <= 1'b0;
      rf_wn_reg <= '0;
      rf_d_reg  <= '0;
      src_reg   <= WB_NONE;
    end else if (b_ready) begin
      rf_we_reg <= (b_wn != '0);
      rf_wn_reg <= b_wn;
      rf_d_reg  <= b_d;
      src_reg   <= WB_B;
    end else if (a_eff) begin
      rf_we_reg <= 1'b1;
      rf_wn_reg <= a_wn;
      rf_d_reg  <= a_d;
      src_reg   <= WB_A;
    end else begin
      rf_we_reg <= 1'b0;
      src_reg   <= WB_NONE;
    end
  end

  // Starvation counter: counts cycles B waits, saturating at the limit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                   cnt_reg <= '0;
    else if (b_valid && !b_ready) cnt_reg <= (cnt_reg < LIMIT) ? cnt_reg + 1'b1 : cnt_reg;
    else                         cnt_reg <= '0;
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

  assign rf_we = rf_we_reg;
  assign rf_wn = rf_wn_reg;
  assign rf_d  = rf_d_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter. Each vector is one clock cycle:
// inputs driven just after the rising edge, outputs checked on the falling edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        a_we;
  logic [4:0]  a_wn;
  logic [31:0] a_d;
  logic        b_valid;
  logic [4:0]  b_wn;
  logic [31:0] b_d;
  logic        b_ready;
  logic        stall_a;
  logic        sb_set;
  logic [4:0]  sb_wn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic        busy_a;
  logic        busy_b;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .clrn(clrn),
    .a_we(a_we), .a_wn(a_wn), .a_d(a_d),
    .b_valid(b_valid), .b_wn(b_wn), .b_d(b_d),
    .b_ready(b_ready), .stall_a(stall_a),
    .sb_set(sb_set), .sb_wn(sb_wn),
    .rna(rna), .rnb(rnb), .busy_a(busy_a), .busy_b(busy_b),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .err(err)
  );

  typedef struct {
    logic        a_we;
    logic [4:0]  a_wn;
    logic [31:0] a_d;
    logic        b_valid;
    logic [4:0]  b_wn;
    logic [31:0] b_d;
    logic        sb_set;
    logic [4:0]  sb_wn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        e_b_ready;
    logic        e_stall_a;
    logic        e_busy_a;
    logic        e_busy_b;
    logic        e_rf_we;
    logic [4:0]  e_rf_wn;
    logic [31:0] e_rf_d;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic aw, input logic [4:0] awn, input logic [31:0] ad,
    input logic bv, input logic [4:0] bwn, input logic [31:0] bd,
    input logic ss, input logic [4:0] swn, input logic [4:0] ra, input logic [4:0] rb,
    input logic ebr, input logic est, input logic eba, input logic ebb,
    input logic ewe, input logic [4:0] ewn, input logic [31:0] ed, input logic eer);
    vec_t v;
    v.a_we = aw; v.a_wn = awn; v.a_d = ad;
    v.b_valid = bv; v.b_wn = bwn; v.b_d = bd;
    v.sb_set = ss; v.sb_wn = swn; v.rna = ra; v.rnb = rb;
    v.e_b_ready = ebr; v.e_stall_a = est; v.e_busy_a = eba; v.e_busy_b = ebb;
    v.e_rf_we = ewe; v.e_rf_wn = ewn; v.e_rf_d = ed; v.e_err = eer;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    a_we = 0; a_wn = 0; a_d = 0;
    b_valid = 0; b_wn = 0; b_d = 0;
    sb_set = 0; sb_wn = 0; rna = 0; rnb = 0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_vec(input vec_t v, input int idx);
    int e0;
    e0 = errors;
    a_we = v.a_we; a_wn = v.a_wn; a_d = v.a_d;
    b_valid = v.b_valid; b_wn = v.b_wn; b_d = v.b_d;
    sb_set = v.sb_set; sb_wn = v.sb_wn; rna = v.rna; rnb = v.rnb;
    @(negedge clk);
    chk("b_ready", idx, {31'd0, b_ready}, {31'd0, v.e_b_ready});
    chk("stall_a", idx, {31'd0, stall_a}, {31'd0, v.e_stall_a});
    chk("busy_a",  idx, {31'd0, busy_a},  {31'd0, v.e_busy_a});
    chk("busy_b",  idx, {31'd0, busy_b},  {31'd0, v.e_busy_b});
    chk("rf_we",   idx, {31'd0, rf_we},   {31'd0, v.e_rf_we});
    chk("rf_wn",   idx, {27'd0, rf_wn},   {27'd0, v.e_rf_wn});
    chk("rf_d",    idx, rf_d,             v.e_rf_d);
    chk("err",     idx, {31'd0, err},     {31'd0, v.e_err});
    $display("vec %0d: b_ready=%0b stall_a=%0b busy=%0b%0b rf_we=%0b rf_wn=%0d rf_d=0x%0h err=%0b %s",
             idx, b_ready, stall_a, busy_a, busy_b, rf_we, rf_wn, rf_d, err,
             (errors == e0) ? "ok" : "bad");
    @(posedge clk); #1;
  endtask

  vec_t t1[17];
  vec_t t2[13];

  initial begin
    //            aw awn  a_d        bv bwn b_d         ss swn ra rb  ebr est eba ebb ewe ewn ed          eer
    // A-only write, then B-only transfer to r7.
    t1[0]  = mk(1, 3, 32'h11,   0, 0, 0,        0, 0, 3, 7,  0, 0, 0, 0,  0, 0, 32'h0,    0);
    t1[1]  = mk(0, 0, 0,        0, 0, 0,        1, 7, 3, 7,  0, 0, 0, 0,  1, 3, 32'h11,   0);
    t1[2]  = mk(0, 0, 0,        1, 7, 32'hDEAD, 0, 0, 3, 7,  1, 0, 0, 1,  0, 3, 32'h11,   0);
    t1[3]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 3, 7,  0, 0, 0, 1,  1, 7, 32'hDEAD, 0);
    t1[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 3, 7,  0, 0, 0, 0,  0, 7, 32'hDEAD, 0);
    // Starvation: A hammers r1 while B waits with r9.
    t1[5]  = mk(1, 1, 32'hA1,   0, 0, 0,        1, 9, 9, 1,  0, 0, 0, 0,  0, 7, 32'hDEAD, 0);
    t1[6]  = mk(1, 1, 32'hA2,   1, 9, 32'h99,   0, 0, 9, 1,  0, 0, 1, 0,  1, 1, 32'hA1,   0);
    t1[7]  = mk(1, 1, 32'hA3,   1, 9, 32'h99,   0, 0, 9, 1,  0, 0, 1, 0,  1, 1, 32'hA2,   0);
    t1[8]  = mk(1, 1, 32'hA4,   1, 9, 32'h99,   0, 0, 9, 1,  0, 0, 1, 0,  1, 1, 32'hA3,   0);
    t1[9]  = mk(1, 1, 32'hA5,   1, 9, 32'h99,   0, 0, 9, 1,  0, 0, 1, 0,  1, 1, 32'hA4,   0);
    t1[10] = mk(1, 1, 32'hA6,   1, 9, 32'h99,   0, 0, 9, 1,  1, 1, 1, 0,  1, 1, 32'hA5,   0);
    t1[11] = mk(1, 1, 32'hA6,   0, 0, 0,        0, 0, 9, 1,  0, 0, 1, 0,  1, 9, 32'h99,   0);
    t1[12] = mk(0, 0, 0,        0, 0, 0,        0, 0, 9, 1,  0, 0, 0, 0,  1, 1, 32'hA6,   0);
    // r0 handling: A to r0 yields to B; B to r0 is granted, not written, flags err.
    t1[13] = mk(0, 0, 0,        0, 0, 0,        1, 6, 6, 0,  0, 0, 0, 0,  0, 1, 32'hA6,   0);
    t1[14] = mk(1, 0, 32'h55,   1, 6, 32'h66,   0, 0, 6, 0,  1, 0, 1, 0,  0, 1, 32'hA6,   0);
    t1[15] = mk(0, 0, 0,        1, 0, 32'h77,   0, 0, 6, 0,  1, 0, 1, 0,  1, 6, 32'h66,   0);
    t1[16] = mk(0, 0, 0,        0, 0, 0,        0, 0, 6, 0,  0, 0, 0, 0,  0, 0, 32'h77,   1);

    // After reset: counter must restart from 0, then same-edge set/clear, then WAW.
    t2[0]  = mk(0, 0, 0,        0, 0, 0,        1, 5, 5, 4,  0, 0, 0, 0,  0, 0, 32'h0,    0);
    t2[1]  = mk(1, 2, 32'h22,   1, 5, 32'h55,   0, 0, 5, 4,  0, 0, 1, 0,  0, 0, 32'h0,    0);
    t2[2]  = mk(1, 2, 32'h22,   1, 5, 32'h55,   0, 0, 5, 4,  0, 0, 1, 0,  1, 2, 32'h22,   0);
    t2[3]  = mk(1, 2, 32'h22,   1, 5, 32'h55,   0, 0, 5, 4,  0, 0, 1, 0,  1, 2, 32'h22,   0);
    t2[4]  = mk(1, 2, 32'h22,   1, 5, 32'h55,   0, 0, 5, 4,  0, 0, 1, 0,  1, 2, 32'h22,   0);
    t2[5]  = mk(1, 2, 32'h22,   1, 5, 32'h55,   0, 0, 5, 4,  1, 1, 1, 0,  1, 2, 32'h22,   0);
    t2[6]  = mk(1, 2, 32'h22,   0, 0, 0,        0, 0, 5, 4,  0, 0, 1, 0,  1, 5, 32'h55,   0);
    t2[7]  = mk(0, 0, 0,        0, 0, 0,        1, 4, 5, 4,  0, 0, 0, 0,  1, 2, 32'h22,   0);
    t2[8]  = mk(0, 0, 0,        1, 4, 32'h44,   0, 0, 5, 4,  1, 0, 0, 1,  0, 2, 32'h22,   0);
    t2[9]  = mk(0, 0, 0,        0, 0, 0,        1, 4, 5, 4,  0, 0, 0, 1,  1, 4, 32'h44,   0);
    t2[10] = mk(0, 0, 0,        0, 0, 0,        0, 0, 5, 4,  0, 0, 0, 1,  0, 4, 32'h44,   0);
    t2[11] = mk(1, 4, 32'h4A,   0, 0, 0,        0, 0, 5, 4,  0, 0, 0, 1,  0, 4, 32'h44,   0);
    t2[12] = mk(0, 0, 0,        0, 0, 0,        0, 0, 5, 4,  0, 0, 0, 1,  1, 4, 32'h4A,   1);

    // Power-on reset.
    drive_idle();
    clrn = 1'b0;
    #2;
    chk("reset_rf_we", -1, {31'd0, rf_we}, 32'd0);
    chk("reset_rf_d",  -1, rf_d,           32'd0);
    chk("reset_err",   -1, {31'd0, err},   32'd0);
    $display("reset: rf_we=%0b rf_wn=%0d rf_d=0x%0h err=%0b", rf_we, rf_wn, rf_d, err);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec(t1[i], i);

    // Reset mid-transfer: r5 issued, B waiting behind A, err already set.
    drive_idle();
    sb_set = 1; sb_wn = 5; rna = 5;
    @(posedge clk); #1;
    sb_set = 0; sb_wn = 0;
    a_we = 1; a_wn = 2; a_d = 32'h22;
    b_valid = 1; b_wn = 5; b_d = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #2;
    clrn = 1'b0;
    #1;
    chk("midrst_rf_we",  100, {31'd0, rf_we},  32'd0);
    chk("midrst_rf_wn",  100, {27'd0, rf_wn},  32'd0);
    chk("midrst_rf_d",   100, rf_d,            32'd0);
    chk("midrst_err",    100, {31'd0, err},    32'd0);
    chk("midrst_busy5",  100, {31'd0, busy_a}, 32'd0);
    $display("mid-transfer reset: rf_we=%0b rf_wn=%0d rf_d=0x%0h err=%0b busy_a=%0b",
             rf_we, rf_wn, rf_d, err, busy_a);
    drive_idle();
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(t2[i], 200 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
